// File: rtl/bin_to_bcd_digits.sv
// Binary to four-digit BCD converter using sequential double-dabble.
// One add-3/shift iteration runs per clock. The digit outputs change only
// when a conversion completes, so they can drive seven-segment decoders directly.
// Optional feature macro: LEADING_ZERO_BLANK_EN enables the leading-zero
// blank flags. When it is undefined, digit_blank is tied to 4'b0000.
module bin_to_bcd_digits #(
  parameter int BIN_W = 10
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic [3:0]       digit3,
  output logic [3:0]       digit2,
  output logic [3:0]       digit1,
  output logic [3:0]       digit0,
  output logic [3:0]       digit_blank
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] LAST_ITER = 4'(BIN_W - 1);

  logic [1:0]       state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [15:0]      scratch_q, scratch_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [15:0]      digits_q;
  logic [15:0]      adjusted;
  logic [15:0]      shifted;
  logic             loadDigits;

  // Add 3 to every scratch nibble >= 5, then shift in the next binary MSB
  always_comb begin
    adjusted = scratch_q;
    for (int i = 0; i < 4; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    shifted = (adjusted << 1) | {15'd0, bin_q[BIN_W-1]};
  end

  // Next-state logic: capture in IDLE, iterate BIN_W times, then pulse done once
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    loadDigits = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = CONV;
          bin_d     = bin_in;
          scratch_d = '0;
          cnt_d     = '0;
        end
      end
      CONV: begin
        bin_d     = bin_q << 1;
        scratch_d = shifted;
        cnt_d     = cnt_q + 4'd1;
        if (cnt_q == LAST_ITER) begin
          state_d    = DONE;
          loadDigits = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Digits load only from the final iteration's result
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      digits_q  <= '0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      if (loadDigits) begin
        digits_q <= shifted;
      end
    end
  end

  assign busy   = (state_q == CONV);
  assign done   = (state_q == DONE);
  assign digit3 = digits_q[15:12];
  assign digit2 = digits_q[11:8];
  assign digit1 = digits_q[7:4];
  assign digit0 = digits_q[3:0];

`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0] blank_q, blank_d;

  // Blank a digit only if it and every more significant digit are zero. The ones digit always shows
  always_comb begin
    blank_d    = 4'b0000;
    blank_d[3] = (shifted[15:12] == 4'd0);
    blank_d[2] = blank_d[3] && (shifted[11:8] == 4'd0);
    blank_d[1] = blank_d[2] && (shifted[7:4] == 4'd0);
    blank_d[0] = 1'b0;
  end

  // Blank flags update together with the digits, so they never disagree
  always_ff @(posedge clk) begin
    if (!resetn) begin
      blank_q <= 4'b1110;
    end else if (loadDigits) begin
      blank_q <= blank_d;
    end
  end

  assign digit_blank = blank_q;
`else
  assign digit_blank = 4'b0000;
`endif

endmodule

// File: tb/tb_bin_to_bcd_digits.sv
// Self-checking bench for bin_to_bcd_digits (BIN_W = 10).
// This bench applies table-driven vectors. It also runs hand-written sequences for
// bin_in changing during a conversion, for start held high, and for a reset that aborts a conversion.
// A scoreboard queue holds the expected digits until done is observed.
module tb_bin_to_bcd_digits;

  localparam int BIN_W = 10;

  logic             clk = 1'b0;
  logic             resetn;
  logic             start;
  logic [BIN_W-1:0] bin_in;
  logic             busy;
  logic             done;
  logic [3:0]       digit3, digit2, digit1, digit0;
  logic [3:0]       digit_blank;

  typedef struct {
    logic [BIN_W-1:0] bin;
    logic [15:0]      digits;
  } vec_t;

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  blank;
  } exp_t;

  vec_t        vecs [9];
  exp_t        sbQ [$];
  int          checks = 0;
  int          errors = 0;
  int          doneCount = 0;
  logic        monitorOn = 1'b0;
  logic [15:0] digitsHold;
  logic [3:0]  blankHold;

  bin_to_bcd_digits #(.BIN_W(BIN_W)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .bin_in      (bin_in),
    .busy        (busy),
    .done        (done),
    .digit3      (digit3),
    .digit2      (digit2),
    .digit1      (digit1),
    .digit0      (digit0),
    .digit_blank (digit_blank)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Reference leading-zero blank pattern for a set of BCD digits
  function automatic logic [3:0] refBlank(input logic [15:0] d);
`ifdef LEADING_ZERO_BLANK_EN
    logic b3, b2, b1;
    b3 = (d[15:12] == 4'd0);
    b2 = b3 && (d[11:8] == 4'd0);
    b1 = b2 && (d[7:4] == 4'd0);
    return {b3, b2, b1, 1'b0};
`else
    return 4'b0000;
`endif
  endfunction

  function automatic logic [3:0] resetBlank();
`ifdef LEADING_ZERO_BLANK_EN
    return 4'b1110;
`else
    return 4'b0000;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Scoreboard monitor: pop on done, otherwise the outputs must hold their last result
  always @(negedge clk) begin
    if (monitorOn) begin
      if (done) begin
        doneCount++;
        if (sbQ.size() == 0) begin
          checkOutput("unexpectedDone", 32'(done), 32'(0));
        end else begin
          exp_t e;
          e = sbQ.pop_front();
          digitsHold = e.digits;
          blankHold  = e.blank;
          checkOutput("digits", 32'({digit3, digit2, digit1, digit0}), 32'(e.digits));
          checkOutput("blank", 32'(digit_blank), 32'(e.blank));
        end
      end else begin
        checkOutput("holdOutputs", 32'({digit_blank, digit3, digit2, digit1, digit0}),
                    32'({blankHold, digitsHold}));
      end
    end
  end

  // One conversion with cycle-accurate busy/done checks; optionally disturb inputs mid-conversion
  task automatic applyStimulus(input logic [BIN_W-1:0] v, input logic [15:0] expD, input bit disturb);
    exp_t e;
    e.digits = expD;
    e.blank  = refBlank(expD);
    @(posedge clk); #1;
    start  = 1'b1;
    bin_in = v;
    sbQ.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= BIN_W + 2; c++) begin
      @(negedge clk);
      checkOutput("busy", 32'(busy), 32'(c <= BIN_W));
      checkOutput("done", 32'(done), 32'(c == BIN_W + 1));
      if (disturb && c == 3) begin
        bin_in = 5;
        start  = 1'b1;
      end
      if (c == BIN_W + 1) start = 1'b0;
    end
    @(negedge clk);
    checkOutput("noRestart", 32'(busy), 32'(0));
    checkOutput("scoreboardEmpty", 32'(sbQ.size()), 32'(0));
  endtask

  initial begin
    vecs[0] = '{10'd0,    16'h0000};
    vecs[1] = '{10'd1023, 16'h1023};
    vecs[2] = '{10'd639,  16'h0639};
    vecs[3] = '{10'd479,  16'h0479};
    vecs[4] = '{10'd999,  16'h0999};
    vecs[5] = '{10'd1000, 16'h1000};
    vecs[6] = '{10'd512,  16'h0512};
    vecs[7] = '{10'd7,    16'h0007};
    vecs[8] = '{10'd80,   16'h0080};

    resetn = 1'b0;
    start  = 1'b1;
    bin_in = '0;
    repeat (3) @(posedge clk);
    #1;
    digitsHold = 16'h0000;
    blankHold  = resetBlank();
    @(negedge clk);
    checkOutput("resetBusy", 32'(busy), 32'(0));
    checkOutput("resetDone", 32'(done), 32'(0));
    checkOutput("resetDigits", 32'({digit3, digit2, digit1, digit0}), 32'(0));
    checkOutput("resetBlank", 32'(digit_blank), 32'(resetBlank()));
    start     = 1'b0;
    resetn    = 1'b1;
    monitorOn = 1'b1;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].bin, vecs[i].digits, 1'b0);
    end

    $display("[TB] bin_in change and start during conversion");
    applyStimulus(10'd639, 16'h0639, 1'b1);

    $display("[TB] back-to-back conversions with start held high");
    @(posedge clk); #1;
    start  = 1'b1;
    bin_in = 10'd479;
    for (int k = 0; k < 3; k++) sbQ.push_back('{16'h0479, refBlank(16'h0479)});
    @(posedge clk); #1;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      checkOutput("b2bBusy", 32'(busy), 32'((c % 12) >= 1 && (c % 12) <= 10));
      checkOutput("b2bDone", 32'(done), 32'((c % 12) == 11));
      if (c == 35) start = 1'b0;
    end
    @(negedge clk);
    checkOutput("b2bStopped", 32'(busy), 32'(0));
    checkOutput("b2bScoreboardEmpty", 32'(sbQ.size()), 32'(0));

    $display("[TB] reset aborts conversion");
    @(posedge clk); #1;
    start  = 1'b1;
    bin_in = 10'd300;
    sbQ.push_back('{16'h0300, refBlank(16'h0300)});
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checkOutput("abortBusyPre", 32'(busy), 32'(1));
      if (c == 5) begin
        resetn = 1'b0;
        start  = 1'b1;
      end
    end
    @(posedge clk); #1;
    sbQ.delete();
    digitsHold = 16'h0000;
    blankHold  = resetBlank();
    @(posedge clk); #1;
    resetn = 1'b1;
    start  = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      checkOutput("abortBusy", 32'(busy), 32'(0));
      checkOutput("abortDone", 32'(done), 32'(0));
    end

    checkOutput("totalDonePulses", 32'(doneCount), 32'(13));
    monitorOn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
